// File: rtl/taxi_eth_lb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : taxi_eth_lb_pkg
//  Description : Shared types and constants for the Ethernet loopback
//                swap block: mode and state encodings, header length,
//                broadcast address and a MAC byte-select helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package taxi_eth_lb_pkg;

    typedef enum logic [1:0] {
        LB_PASS       = 2'd0,
        LB_SWAP       = 2'd1,
        LB_SWAP_LOCAL = 2'd2,
        LB_DROP       = 2'd3
    } lb_mode_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        EMIT = 3'd2,
        PASS = 3'd3,
        DROP = 3'd4
    } lb_state_t;

    localparam int          HDR_LEN   = 12;
    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    // Byte idx of a MAC address in wire order. Byte 0 (first on the wire)
    // lives in the most significant octet, so 48'h5A5152535455 goes out
    // as 5A,51,52,53,54,55.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = mac[47:40];
            4'd1:    b = mac[39:32];
            4'd2:    b = mac[31:24];
            4'd3:    b = mac[23:16];
            4'd4:    b = mac[15:8];
            default: b = mac[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/taxi_axis_if.sv
`default_nettype none
// ============================================================================
//  Module      : taxi_axis_if
//  Description : Minimal AXI-stream interface (tdata/tvalid/tready/tlast/
//                tid/tuser) with source and sink modports.
//  Revision    : 1.0 - initial release
// ============================================================================
interface taxi_axis_if #(
    parameter int DATA_W = 8,
    parameter int ID_W   = 8,
    parameter int USER_W = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [USER_W-1:0] tuser;

    modport src (output tdata, tvalid, tlast, tid, tuser, input tready);
    modport snk (input tdata, tvalid, tlast, tid, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/taxi_eth_lb_stats.sv
`default_nettype none
// ============================================================================
//  Module      : taxi_eth_lb_stats
//  Description : Four free-running frame counters that wrap modulo
//                2^STAT_W, each advanced by a one-cycle strobe.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                inc_rx/tx/drop/runt - increment strobes
//                rx/tx/drop/runt_frames - counter values
//  Revision    : 1.0 - initial release
// ============================================================================
module taxi_eth_lb_stats #(
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_rx,
    input  logic              inc_tx,
    input  logic              inc_drop,
    input  logic              inc_runt,
    output logic [STAT_W-1:0] rx_frames,
    output logic [STAT_W-1:0] tx_frames,
    output logic [STAT_W-1:0] drop_frames,
    output logic [STAT_W-1:0] runt_frames
);
    localparam logic [STAT_W-1:0] c_one = STAT_W'(1);

    logic [3:0]        w_inc;
    logic [STAT_W-1:0] w_cnt [4];

    assign w_inc = {inc_runt, inc_drop, inc_tx, inc_rx};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            logic [STAT_W-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst)
                    r_cnt <= '0;
                else if (w_inc[gi])
                    r_cnt <= r_cnt + c_one;
            end
            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    assign rx_frames   = w_cnt[0];
    assign tx_frames   = w_cnt[1];
    assign drop_frames = w_cnt[2];
    assign runt_frames = w_cnt[3];
endmodule
`default_nettype wire

// File: rtl/taxi_eth_lb_swap.sv
`default_nettype none
// ============================================================================
//  Module      : taxi_eth_lb_swap
//  Description : Byte-wide Ethernet loopback between MAC RX and MAC TX.
//                Passes, swaps or rewrites the MAC header, filters on the
//                destination address, drops runts and counts frames.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                s_axis          - frames from MAC RX (sink)
//                m_axis          - frames to MAC TX (source)
//                cfg_mode        - 0 pass, 1 swap, 2 swap + local src, 3 drop
//                cfg_local_mac   - local MAC, byte 0 in bits [47:40]
//                stat_*_frames   - rx / tx / drop / runt frame counters
//                busy            - state machine is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module taxi_eth_lb_swap #(
    parameter int ID_W      = 8,
    parameter int USER_W    = 1,
    parameter int FILTER_EN = 1,
    parameter int STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    taxi_axis_if.snk          s_axis,
    taxi_axis_if.src          m_axis,
    input  logic [1:0]        cfg_mode,
    input  logic [47:0]       cfg_local_mac,
    output logic [STAT_W-1:0] stat_rx_frames,
    output logic [STAT_W-1:0] stat_tx_frames,
    output logic [STAT_W-1:0] stat_drop_frames,
    output logic [STAT_W-1:0] stat_runt_frames,
    output logic              busy
);
    import taxi_eth_lb_pkg::*;

    localparam logic [3:0] c_last_idx = 4'(HDR_LEN - 1);
    localparam logic [3:0] c_src_off  = 4'd6;

    lb_state_t         r_state;
    lb_mode_t          r_mode;
    logic [47:0]       r_local_mac;
    logic [ID_W-1:0]   r_tid;
    logic [7:0]        r_hdr [HDR_LEN];
    logic [3:0]        r_idx;
    logic              r_last;
    logic [USER_W-1:0] r_user;

    lb_mode_t          w_cfg_mode;
    logic              w_s_ready;
    logic              w_m_valid;
    logic              w_m_last;
    logic [7:0]        w_m_data;
    logic [ID_W-1:0]   w_m_tid;
    logic [USER_W-1:0] w_m_user;
    logic              w_s_fire;
    logic              w_m_fire;
    logic              w_hdr_done;
    logic              w_filter_drop;
    logic [47:0]       w_dst;
    logic [7:0]        w_emit_byte;
    logic [3:0]        w_emit_sub;
    logic              w_inc_drop;
    logic              w_inc_runt;

    assign w_cfg_mode    = lb_mode_t'(cfg_mode);
    assign w_dst         = {r_hdr[0], r_hdr[1], r_hdr[2], r_hdr[3], r_hdr[4], r_hdr[5]};
    assign w_filter_drop = (FILTER_EN != 0) && (w_dst != r_local_mac) && (w_dst != BCAST_MAC);
    assign w_emit_sub    = r_idx - c_src_off;

    // Outgoing header: captured source first, then captured destination
    // (swap) or the local address latched at byte 0 (swap + local src).
    always_comb begin
        w_emit_byte = 8'd0;
        if (r_idx < c_src_off)
            w_emit_byte = r_hdr[r_idx + c_src_off];
        else if (r_mode == LB_SWAP)
            w_emit_byte = r_hdr[w_emit_sub];
        else
            w_emit_byte = mac_byte(r_local_mac, w_emit_sub);
    end

    // Stream muxing. IDLE with pass mode already behaves as PASS so the
    // first beat of a pass frame is forwarded with no added latency.
    always_comb begin
        w_s_ready = 1'b0;
        w_m_valid = 1'b0;
        w_m_data  = 8'd0;
        w_m_last  = 1'b0;
        w_m_tid   = '0;
        w_m_user  = '0;
        if (!rst) begin
            if ((r_state == PASS) || ((r_state == IDLE) && (w_cfg_mode == LB_PASS))) begin
                w_s_ready = m_axis.tready;
                w_m_valid = s_axis.tvalid;
                w_m_data  = s_axis.tdata;
                w_m_last  = s_axis.tlast;
                w_m_tid   = s_axis.tid;
                w_m_user  = s_axis.tuser;
            end else if (r_state == EMIT) begin
                w_m_valid = 1'b1;
                w_m_data  = w_emit_byte;
                w_m_tid   = r_tid;
                w_m_last  = (r_idx == c_last_idx) && r_last;
                w_m_user  = (r_idx == c_last_idx) ? r_user : '0;
            end else begin
                w_s_ready = 1'b1;
            end
        end
    end

    assign s_axis.tready = w_s_ready;
    assign m_axis.tvalid = w_m_valid;
    assign m_axis.tdata  = w_m_data;
    assign m_axis.tlast  = w_m_last;
    assign m_axis.tid    = w_m_tid;
    assign m_axis.tuser  = w_m_user;

    assign w_s_fire   = s_axis.tvalid && w_s_ready;
    assign w_m_fire   = w_m_valid && m_axis.tready;
    assign w_hdr_done = (r_state == HDR) && w_s_fire && (r_idx == c_last_idx);

    // A header-path frame ending before byte 11 (including a one-byte
    // frame ending in IDLE) is a runt.
    assign w_inc_runt = w_s_fire && s_axis.tlast &&
        (((r_state == IDLE) && ((w_cfg_mode == LB_SWAP) || (w_cfg_mode == LB_SWAP_LOCAL))) ||
         ((r_state == HDR) && (r_idx < c_last_idx)));

    // Filter drops count once at byte 11; mode-3 drops count at tlast.
    assign w_inc_drop = (w_hdr_done && w_filter_drop) ||
        (w_s_fire && s_axis.tlast &&
         (((r_state == IDLE) && (w_cfg_mode == LB_DROP)) ||
          ((r_state == DROP) && (r_mode == LB_DROP))));

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= LB_PASS;
            r_local_mac <= '0;
            r_tid       <= '0;
            r_idx       <= '0;
            r_last      <= 1'b0;
            r_user      <= '0;
            for (int i = 0; i < HDR_LEN; i++)
                r_hdr[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_s_fire) begin
                        r_mode      <= w_cfg_mode;
                        r_local_mac <= cfg_local_mac;
                        r_tid       <= s_axis.tid;
                        case (w_cfg_mode)
                            LB_PASS: r_state <= s_axis.tlast ? IDLE : PASS;
                            LB_DROP: r_state <= s_axis.tlast ? IDLE : DROP;
                            default: begin
                                r_hdr[0] <= s_axis.tdata;
                                r_idx    <= 4'd1;
                                r_state  <= s_axis.tlast ? IDLE : HDR;
                            end
                        endcase
                    end
                end
                HDR: begin
                    if (w_s_fire) begin
                        r_hdr[r_idx] <= s_axis.tdata;
                        r_idx        <= r_idx + 4'd1;
                        if (r_idx == c_last_idx) begin
                            r_idx <= '0;
                            if (w_filter_drop) begin
                                r_state <= s_axis.tlast ? IDLE : DROP;
                            end else begin
                                r_state <= EMIT;
                                r_last  <= s_axis.tlast;
                                r_user  <= s_axis.tuser;
                            end
                        end else if (s_axis.tlast) begin
                            r_state <= IDLE;
                        end
                    end
                end
                EMIT: begin
                    if (w_m_fire) begin
                        if (r_idx == c_last_idx) begin
                            r_idx   <= '0;
                            r_state <= r_last ? IDLE : PASS;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                PASS: begin
                    if (w_m_fire && s_axis.tlast)
                        r_state <= IDLE;
                end
                DROP: begin
                    if (w_s_fire && s_axis.tlast)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    taxi_eth_lb_stats #(
        .STAT_W (STAT_W)
    ) u_stats (
        .clk         (clk),
        .rst         (rst),
        .inc_rx      (w_s_fire && s_axis.tlast),
        .inc_tx      (w_m_fire && w_m_last),
        .inc_drop    (w_inc_drop),
        .inc_runt    (w_inc_runt),
        .rx_frames   (stat_rx_frames),
        .tx_frames   (stat_tx_frames),
        .drop_frames (stat_drop_frames),
        .runt_frames (stat_runt_frames)
    );
endmodule
`default_nettype wire

// File: tb/tb_taxi_eth_lb_swap.sv
`default_nettype none
// ============================================================================
//  Module      : tb_taxi_eth_lb_swap
//  Description : Self-checking bench for taxi_eth_lb_swap. A frame-level
//                model predicts every output beat and the counters; a
//                monitor compares each output handshake against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_taxi_eth_lb_swap;

    localparam int STAT_W = 32;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
        logic [7:0] id;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        cfg_mode;
    logic [47:0]       cfg_local_mac;
    logic [STAT_W-1:0] stat_rx, stat_tx, stat_drop, stat_runt;
    logic              busy;

    beat_t      exp_q [$];
    logic [7:0] cap [$];
    logic [7:0] frame_buf [64];
    int         cap_same = 0;
    int         checks = 0;
    int         errors = 0;
    int         exp_rx = 0, exp_tx = 0, exp_drop = 0, exp_runt = 0;
    int         rdy_mode = 0;

    always #5 clk = ~clk;

    taxi_axis_if #(.DATA_W(8), .ID_W(8), .USER_W(1)) s_if ();
    taxi_axis_if #(.DATA_W(8), .ID_W(8), .USER_W(1)) m_if ();

    taxi_eth_lb_swap #(
        .ID_W(8), .USER_W(1), .FILTER_EN(1), .STAT_W(STAT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis           (s_if),
        .m_axis           (m_if),
        .cfg_mode         (cfg_mode),
        .cfg_local_mac    (cfg_local_mac),
        .stat_rx_frames   (stat_rx),
        .stat_tx_frames   (stat_tx),
        .stat_drop_frames (stat_drop),
        .stat_runt_frames (stat_runt),
        .busy             (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Sink ready: 0 = always ready, 1 = random 50%, 2 = never ready.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = ($urandom_range(0, 1) == 1);
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    // Output monitor: every handshake against the model, plus stability
    // of a stalled beat.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        beat_t      e, a;
        prev_stall = 1'b0;
        prev_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!m_if.tvalid || m_if.tdata != prev_data) begin
                        errors++;
                        $display("FAIL stall hold: got v=%b d=%h expected v=1 d=%h",
                                 m_if.tvalid, m_if.tdata, prev_data);
                    end
                end
                prev_stall = m_if.tvalid && !m_if.tready;
                prev_data  = m_if.tdata;
                if (m_if.tvalid && m_if.tready) begin
                    checks++;
                    a = {m_if.tdata, m_if.tlast, m_if.tuser[0], m_if.tid};
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL out beat: got unexpected d=%h l=%b, expected none", a.d, a.l);
                    end else begin
                        e = exp_q.pop_front();
                        if (a !== e) begin
                            errors++;
                            $display("FAIL out beat: got d=%h l=%b u=%b id=%h expected d=%h l=%b u=%b id=%h",
                                     a.d, a.l, a.u, a.id, e.d, e.l, e.u, e.id);
                        end
                    end
                    cap.push_back(m_if.tdata);
                    if (s_if.tvalid && s_if.tready && s_if.tdata == m_if.tdata)
                        cap_same++;
                end
            end
        end
    end

    // Frame-level model of what the block must emit and count.
    task automatic model_frame(input int n, input int mode, input logic [7:0] id, input logic bad);
        logic [7:0]  o [64];
        logic [47:0] dst;
        exp_rx++;
        if (mode == 3) begin
            exp_drop++;
        end else if (mode == 0) begin
            for (int i = 0; i < n; i++)
                exp_q.push_back({frame_buf[i], (i == n - 1), (bad && i == n - 1), id});
            exp_tx++;
        end else if (n < 12) begin
            exp_runt++;
        end else begin
            dst = {frame_buf[0], frame_buf[1], frame_buf[2], frame_buf[3], frame_buf[4], frame_buf[5]};
            if (dst != cfg_local_mac && dst != 48'hFFFF_FFFF_FFFF) begin
                exp_drop++;
            end else begin
                for (int i = 0; i < n; i++) begin
                    if (i < 6)
                        o[i] = frame_buf[i + 6];
                    else if (i < 12)
                        o[i] = (mode == 1) ? frame_buf[i - 6] : cfg_local_mac[8 * (11 - i) +: 8];
                    else
                        o[i] = frame_buf[i];
                    exp_q.push_back({o[i], (i == n - 1), (bad && i == n - 1), id});
                end
                exp_tx++;
            end
        end
    endtask

    task automatic fill(input logic [47:0] dst, input logic [47:0] src, input logic [7:0] seed);
        for (int j = 0; j < 6; j++) begin
            frame_buf[j]     = dst[8 * (5 - j) +: 8];
            frame_buf[6 + j] = src[8 * (5 - j) +: 8];
        end
        for (int i = 12; i < 64; i++)
            frame_buf[i] = seed + 8'(i);
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic l, input logic u,
                              input logic [7:0] id, output int stalls);
        logic hs;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tuser  = u;
        s_if.tid    = id;
        s_if.tvalid = 1'b1;
        stalls = 0;
        hs = 1'b0;
        while (!hs && stalls < 200) begin
            @(negedge clk);
            hs = s_if.tready;
            @(posedge clk);
            #1;
            if (!hs) stalls++;
        end
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL input handshake: got no tready in %0d cycles, expected accept", stalls);
        end
    endtask

    task automatic send_frame(input int n, input int mode, input logic [7:0] id, input logic bad,
                              input int change_at, input int new_mode, output int stalls);
        int st;
        cfg_mode = 2'(mode);
        model_frame(n, mode, id, bad);
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            if (i == change_at) cfg_mode = 2'(new_mode);
            drive_beat(frame_buf[i], (i == n - 1), (bad && i == n - 1), id, st);
            stalls += st;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_stats(input string tag);
        chk($sformatf("%s rx", tag),   stat_rx,   exp_rx);
        chk($sformatf("%s tx", tag),   stat_tx,   exp_tx);
        chk($sformatf("%s drop", tag), stat_drop, exp_drop);
        chk($sformatf("%s runt", tag), stat_runt, exp_runt);
    endtask

    task automatic set_ready(input int m);
        rdy_mode = m;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int st;
        rst           = 1'b1;
        s_if.tvalid   = 1'b0;
        s_if.tdata    = 8'd0;
        s_if.tlast    = 1'b0;
        s_if.tuser    = 1'b0;
        s_if.tid      = 8'd0;
        cfg_mode      = 2'd1;
        cfg_local_mac = 48'h02_00_00_00_00_01;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst s_tready", s_if.tready, 0);
        chk("rst m_tvalid", m_if.tvalid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle busy", busy, 0);
        chk("idle s_tready", s_if.tready, 1);
        chk("idle m_tvalid", m_if.tvalid, 0);
        check_stats("reset");
        @(posedge clk);
        #1;

        // Mode 0: 64-byte pass, zero latency
        fill(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 8'h10);
        cap.delete();
        cap_same = 0;
        send_frame(64, 0, 8'h11, 1'b0, -1, 0, st);
        chk("pass stalls", st, 0);
        wait_drain();
        chk("pass beats", cap.size(), 64);
        chk("pass same-cycle", cap_same, 64);
        check_stats("pass");

        // Mode 1: swap
        fill(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 8'h40);
        cap.delete();
        send_frame(60, 1, 8'h22, 1'b0, -1, 0, st);
        wait_drain();
        chk("swap beats", cap.size(), 60);
        chk("swap out[0]", cap[0], 8'h02);
        chk("swap out[5]", cap[5], 8'h02);
        chk("swap out[11]", cap[11], 8'h01);
        chk("swap out[12]", cap[12], 8'h4C);
        chk("swap out[59]", cap[59], 8'h7B);
        check_stats("swap");

        // Mode 2: broadcast dst, local source, bad flag forwarded
        cfg_local_mac = 48'h5A_51_52_53_54_55;
        fill(48'hFF_FF_FF_FF_FF_FF, 48'h02_00_00_00_00_02, 8'h80);
        cap.delete();
        send_frame(60, 2, 8'h33, 1'b1, -1, 0, st);
        wait_drain();
        chk("local out[5]", cap[5], 8'h02);
        chk("local out[6]", cap[6], 8'h5A);
        chk("local out[11]", cap[11], 8'h55);
        check_stats("local");

        // Filter drop
        cfg_local_mac = 48'h02_00_00_00_00_01;
        fill(48'h02_00_00_00_00_99, 48'h02_00_00_00_00_02, 8'h00);
        cap.delete();
        send_frame(60, 1, 8'h44, 1'b0, -1, 0, st);
        chk("filter stalls", st, 0);
        wait_drain();
        chk("filter beats", cap.size(), 0);
        check_stats("filter");

        // Runts, exact 12-byte frame, mode-3 drop, then a normal frame
        fill(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_03, 8'h20);
        send_frame(8, 1, 8'h55, 1'b0, -1, 0, st);
        send_frame(11, 1, 8'h56, 1'b0, -1, 0, st);
        send_frame(12, 1, 8'h57, 1'b1, -1, 0, st);
        send_frame(20, 3, 8'h58, 1'b0, -1, 0, st);
        send_frame(60, 1, 8'h59, 1'b0, -1, 0, st);
        wait_drain();
        check_stats("runt");

        // Random back-pressure, mode change mid-frame
        set_ready(1);
        fill(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 8'hA0);
        cap.delete();
        send_frame(60, 1, 8'h66, 1'b0, 20, 0, st);
        fill(48'h02_00_00_00_00_07, 48'h02_00_00_00_00_08, 8'hC0);
        send_frame(40, 0, 8'h67, 1'b1, -1, 0, st);
        fill(48'hFF_FF_FF_FF_FF_FF, 48'h02_00_00_00_00_09, 8'h30);
        send_frame(30, 1, 8'h68, 1'b0, -1, 0, st);
        wait_drain();
        chk("random beats", cap.size(), 130);
        chk("random out[0]", cap[0], 8'h02);
        chk("random out[11]", cap[11], 8'h01);
        check_stats("random");

        // Reset while emitting the header
        set_ready(2);
        cfg_mode = 2'd1;
        fill(48'h02_00_00_00_00_01, 48'h0A_0B_0C_0D_0E_0F, 8'h00);
        for (int i = 0; i < 12; i++)
            drive_beat(frame_buf[i], 1'b0, 1'b0, 8'h77, st);
        s_if.tdata = frame_buf[12];
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("emit m_tvalid", m_if.tvalid, 1);
        chk("emit m_tdata", m_if.tdata, 8'h0A);
        chk("emit m_tid", m_if.tid, 8'h77);
        chk("emit busy", busy, 1);
        chk("emit s_tready", s_if.tready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        @(negedge clk);
        chk("rst-cycle m_tvalid", m_if.tvalid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_rx = 0; exp_tx = 0; exp_drop = 0; exp_runt = 0;
        @(negedge clk);
        chk("post-rst busy", busy, 0);
        chk("post-rst m_tvalid", m_if.tvalid, 0);
        check_stats("post-rst");
        @(posedge clk);
        #1;

        // Recovery frame after reset
        set_ready(0);
        fill(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_04, 8'h50);
        cap.delete();
        send_frame(30, 1, 8'h78, 1'b0, -1, 0, st);
        wait_drain();
        chk("recover beats", cap.size(), 30);
        chk("recover out[5]", cap[5], 8'h04);
        check_stats("recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
